// File: rtl/scan_sequencer.sv
// scan_sequencer: sequences one film scan from the host scan settings.
//
// Powers the transport motor, waits for it to settle, then for every line issues
// a one-cycle sensor line-start strobe and a burst of D = reso_div + 1 motor step
// pulses. A line lasts max(LINE_PERIOD_CLKS, 2 * D * STEP_PULSE_CLKS) cycles, and
// the next line starts in the cycle right after the previous one ends.
//
// Ports:
//   clk_100M    in   system clock
//   rst         in   asynchronous active-high reset
//   run[7:0]    in   bit0 scan enable (level, start on rising edge), bit1 direction
//   lines[23:0] in   number of lines to scan (0 gives an immediate done pulse)
//   reso_div    in   steps per line minus one
//   line_start  out  one-cycle strobe in the first cycle of each line
//   motor_en    out  motor driver enable for the duration of the scan
//   motor_dir   out  direction latched at scan start
//   motor_step  out  step pulse train
//   busy        out  scan in progress
//   done        out  one-cycle pulse on normal completion
//   line_count  out  lines completed in the current or last scan
module scan_sequencer #(
  parameter int unsigned LINE_PERIOD_CLKS = 10000,
  parameter int unsigned STEP_PULSE_CLKS  = 200,
  parameter int unsigned SETTLE_CLKS      = 50000
) (
  input  logic        clk_100M,
  input  logic        rst,
  input  logic [7:0]  run,
  input  logic [23:0] lines,
  input  logic [7:0]  reso_div,
  output logic        line_start,
  output logic        motor_en,
  output logic        motor_dir,
  output logic        motor_step,
  output logic        busy,
  output logic        done,
  output logic [23:0] line_count
);

  localparam int unsigned TmrW = (LINE_PERIOD_CLKS > 1) ? $clog2(LINE_PERIOD_CLKS) : 1;
  localparam int unsigned PhW  = (STEP_PULSE_CLKS > 1) ? $clog2(STEP_PULSE_CLKS) : 1;
  localparam int unsigned SetW = (SETTLE_CLKS > 1) ? $clog2(SETTLE_CLKS) : 1;

  localparam logic [TmrW-1:0] TmrLast = TmrW'(LINE_PERIOD_CLKS - 1);
  localparam logic [PhW-1:0]  PhLast  = PhW'(STEP_PULSE_CLKS - 1);
  localparam logic [SetW-1:0] SetLast = SetW'(SETTLE_CLKS - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StLine, StFinish} state_e;

  state_e          r_state;
  logic            r_run0;        // previous run[0]
  logic            r_armed;       // run[0] has been seen low since reset
  logic [23:0]     r_lines;
  logic [8:0]      r_d;           // steps per line, 1..256
  logic [SetW-1:0] r_settle_cnt;
  logic [TmrW-1:0] r_line_tmr;    // saturates at TmrLast
  logic [8:0]      r_step_cnt;    // completed steps in this line
  logic [PhW-1:0]  r_phase;       // cycles spent in current high/low half
  logic            r_line_start;
  logic            r_motor_en;
  logic            r_motor_dir;
  logic            r_motor_step;
  logic            r_busy;
  logic            r_done;
  logic [23:0]     r_line_count;

  logic            w_start;
  logic            w_tmr_exp;
  logic            w_phase_last;
  logic            w_steps_done;
  logic            w_line_end;
  logic [23:0]     w_count_inc;
  logic [8:0]      w_step_inc;
  logic            w_unused_run;

  // A level held high through reset must not look like a rising edge, so a
  // start also needs run[0] to have been low at least once since reset.
  assign w_start      = run[0] & ~r_run0 & r_armed;
  assign w_tmr_exp    = (r_line_tmr == TmrLast);
  assign w_phase_last = (r_phase == PhLast);
  assign w_step_inc   = r_step_cnt + 9'd1;
  // Steps count as complete in the last low cycle of the final step, so a
  // step-limited line lasts exactly 2 * D * STEP_PULSE_CLKS cycles.
  assign w_steps_done = (r_step_cnt == r_d) ||
                        ((w_step_inc == r_d) && !r_motor_step && w_phase_last);
  assign w_line_end   = w_tmr_exp && w_steps_done;
  assign w_count_inc  = r_line_count + 24'd1;
  assign w_unused_run = ^run[7:2];

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_run0       <= 1'b0;
      r_armed      <= 1'b0;
      r_lines      <= '0;
      r_d          <= 9'd1;
      r_settle_cnt <= '0;
      r_line_tmr   <= '0;
      r_step_cnt   <= '0;
      r_phase      <= '0;
      r_line_start <= 1'b0;
      r_motor_en   <= 1'b0;
      r_motor_dir  <= 1'b0;
      r_motor_step <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_line_count <= '0;
    end else begin
      r_run0       <= run[0];
      if (!run[0]) begin
        r_armed <= 1'b1;
      end
      r_line_start <= 1'b0;
      r_done       <= 1'b0;

      unique case (r_state)
        StIdle: begin
          r_busy       <= 1'b0;
          r_motor_en   <= 1'b0;
          r_motor_step <= 1'b0;
          if (w_start) begin
            r_line_count <= '0;
            if (lines != 24'd0) begin
              r_lines      <= lines;
              r_d          <= {1'b0, reso_div} + 9'd1;
              r_motor_dir  <= run[1];
              r_busy       <= 1'b1;
              r_motor_en   <= 1'b1;
              r_settle_cnt <= '0;
              r_state      <= StSettle;
            end else begin
              r_done <= 1'b1;
            end
          end
        end

        StSettle: begin
          if (!run[0]) begin
            r_state      <= StIdle;
            r_motor_step <= 1'b0;
            r_motor_en   <= 1'b0;
            r_busy       <= 1'b0;
          end else if (r_settle_cnt == SetLast) begin
            r_state      <= StLine;
            r_line_start <= 1'b1;
            r_motor_step <= 1'b1;
            r_line_tmr   <= '0;
            r_step_cnt   <= '0;
            r_phase      <= '0;
          end else begin
            r_settle_cnt <= r_settle_cnt + SetW'(1);
          end
        end

        StLine: begin
          if (!run[0]) begin
            r_state      <= StIdle;
            r_motor_step <= 1'b0;
            r_motor_en   <= 1'b0;
            r_busy       <= 1'b0;
          end else if (w_line_end) begin
            r_line_count <= w_count_inc;
            if (w_count_inc == r_lines) begin
              r_state      <= StFinish;
              r_done       <= 1'b1;
              r_motor_en   <= 1'b0;
              r_busy       <= 1'b0;
              r_motor_step <= 1'b0;
            end else begin
              // Back-to-back line: strobe and first step in the very next cycle.
              r_line_start <= 1'b1;
              r_motor_step <= 1'b1;
              r_line_tmr   <= '0;
              r_step_cnt   <= '0;
              r_phase      <= '0;
            end
          end else begin
            if (!w_tmr_exp) begin
              r_line_tmr <= r_line_tmr + TmrW'(1);
            end
            if (r_step_cnt != r_d) begin
              if (w_phase_last) begin
                r_phase <= '0;
                if (r_motor_step) begin
                  r_motor_step <= 1'b0;
                end else begin
                  r_step_cnt <= w_step_inc;
                  if (w_step_inc != r_d) begin
                    r_motor_step <= 1'b1;
                  end
                end
              end else begin
                r_phase <= r_phase + PhW'(1);
              end
            end
          end
        end

        StFinish: begin
          r_state <= StIdle;
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign line_start = r_line_start;
  assign motor_en   = r_motor_en;
  assign motor_dir  = r_motor_dir;
  assign motor_step = r_motor_step;
  assign busy       = r_busy;
  assign done       = r_done;
  assign line_count = r_line_count;

endmodule

// File: tb/tb_scan_sequencer.sv
module tb_scan_sequencer;

  localparam int LP     = 100;
  localparam int SP     = 10;
  localparam int SETTLE = 20;
  localparam int FIRST  = SETTLE + 2;  // drive cycle to first line_start
  localparam int STEPP  = 2 * SP;      // step-to-step spacing

  logic        clk_100M;
  logic        rst;
  logic [7:0]  run;
  logic [23:0] lines;
  logic [7:0]  reso_div;
  logic        line_start;
  logic        motor_en;
  logic        motor_dir;
  logic        motor_step;
  logic        busy;
  logic        done;
  logic [23:0] line_count;

  scan_sequencer #(
    .LINE_PERIOD_CLKS(LP),
    .STEP_PULSE_CLKS (SP),
    .SETTLE_CLKS     (SETTLE)
  ) dut (
    .clk_100M  (clk_100M),
    .rst       (rst),
    .run       (run),
    .lines     (lines),
    .reso_div  (reso_div),
    .line_start(line_start),
    .motor_en  (motor_en),
    .motor_dir (motor_dir),
    .motor_step(motor_step),
    .busy      (busy),
    .done      (done),
    .line_count(line_count)
  );

  initial begin
    clk_100M = 1'b0;
    forever #5 clk_100M = ~clk_100M;
  end

  typedef struct {
    int lines;
    int reso;
    bit dir;
    int period;
    int steps;
    int count;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int q_ls[$];
  int q_step[$];
  int q_done[$];
  bit exp_dir    = 1'b0;
  int step_rises = 0;
  bit en_seen    = 1'b0;
  bit prev_step  = 1'b0;
  int hi_len     = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops scoreboard entries when the DUT produces events.
  always @(negedge clk_100M) begin
    cyc = cyc + 1;
    if (rst) begin
      prev_step = 1'b0;
      hi_len    = 0;
    end else begin
      if (line_start) begin
        if (q_ls.size() == 0) chk("line_start_unexpected", cyc, -1);
        else begin
          chk("line_start_cycle", cyc, q_ls.pop_front());
          chk("motor_dir", motor_dir, exp_dir);
        end
      end
      if (motor_step && !prev_step) begin
        step_rises++;
        if (q_step.size() == 0) chk("step_unexpected", cyc, -1);
        else chk("step_rise_cycle", cyc, q_step.pop_front());
      end
      if (motor_step) hi_len++;
      else if (prev_step) begin
        chk("step_high_len", hi_len, SP);
        hi_len = 0;
      end
      if (done) begin
        if (q_done.size() == 0) chk("done_unexpected", cyc, -1);
        else chk("done_cycle", cyc, q_done.pop_front());
      end
      if (motor_en) en_seen = 1'b1;
      prev_step = motor_step;
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(posedge clk_100M);
    #2;
  endtask

  // Drops run low for one cycle, then raises run[0]; c = cycle of the rise.
  task automatic start_scan(input int l, input int r, input bit dir, output int c);
    run = 8'h00;
    @(posedge clk_100M);
    #2;
    lines    = 24'(l);
    reso_div = 8'(r);
    run      = {6'h2A, dir, 1'b1};
    c        = cyc;
  endtask

  task automatic push_lines(input int c, input int n, input int period, input int dpl);
    for (int k = 0; k < n; k++) begin
      q_ls.push_back(c + FIRST + k * period);
      for (int j = 0; j < dpl; j++) q_step.push_back(c + FIRST + k * period + j * STEPP);
    end
  endtask

  task automatic check_drained(input string tag);
    chk({tag, "_ls_pending"}, q_ls.size(), 0);
    chk({tag, "_step_pending"}, q_step.size(), 0);
    chk({tag, "_done_pending"}, q_done.size(), 0);
  endtask

  task automatic run_vec(input vec_t v);
    int c;
    int fin;
    exp_dir    = v.dir;
    step_rises = 0;
    en_seen    = 1'b0;
    start_scan(v.lines, v.reso, v.dir, c);
    if (v.lines == 0) begin
      fin = c + 2;
    end else begin
      push_lines(c, v.lines, v.period, v.steps / v.lines);
      fin = c + FIRST + v.lines * v.period;
      @(negedge clk_100M);
      chk("motor_en_before_start", motor_en, 0);
      @(negedge clk_100M);
      chk("motor_en_next_cycle", motor_en, 1);
      chk("busy_next_cycle", busy, 1);
    end
    q_done.push_back(fin);
    wait_until(fin + 3);
    chk("line_count_final", line_count, v.count);
    chk("step_total", step_rises, v.steps);
    chk("busy_after", busy, 0);
    chk("motor_en_after", motor_en, 0);
    check_drained("vec");
    if (v.lines == 0) chk("zero_lines_motor_en_seen", en_seen, 0);
  endtask

  vec_t vecs[5];
  int   c;
  int   t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{3, 0, 1'b0, 100, 3, 3};   // basic scan
    vecs[1] = '{2, 7, 1'b1, 160, 16, 2};  // step-limited line
    vecs[2] = '{0, 3, 1'b0, 0, 0, 0};     // zero lines
    vecs[3] = '{1, 4, 1'b0, 100, 5, 1};   // steps exactly fill the period
    vecs[4] = '{2, 5, 1'b1, 120, 12, 2};  // step-limited, 6 steps

    // Power-up reset with run[0] already high: must not start on release.
    rst      = 1'b0;
    run      = 8'h01;
    lines    = 24'd3;
    reso_div = 8'd0;
    #3 rst = 1'b1;
    #1;
    chk("por_busy", busy, 0);
    chk("por_motor_en", motor_en, 0);
    chk("por_line_count", line_count, 0);
    repeat (3) @(posedge clk_100M);
    #2 rst = 1'b0;
    wait_until(cyc + 50);
    chk("held_run_no_start_busy", busy, 0);
    chk("held_run_no_start_en", motor_en, 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Abort 30 cycles after the second line_start.
    exp_dir    = 1'b0;
    step_rises = 0;
    start_scan(5, 0, 0, c);
    push_lines(c, 2, LP, 1);
    t = c + FIRST + LP + 30;
    wait_until(t);
    run = 8'h00;
    @(negedge clk_100M);
    chk("abort_busy_before", busy, 1);
    @(negedge clk_100M);
    chk("abort_motor_step", motor_step, 0);
    chk("abort_motor_en", motor_en, 0);
    chk("abort_busy", busy, 0);
    wait_until(t + 150);
    chk("abort_line_count", line_count, 1);
    chk("abort_steps", step_rises, 2);
    check_drained("abort");

    // Latched settings, hold-high no-restart, then re-arm.
    exp_dir    = 1'b0;
    step_rises = 0;
    start_scan(2, 0, 0, c);
    push_lines(c, 2, LP, 1);
    q_done.push_back(c + FIRST + 2 * LP);
    wait_until(c + 30);
    reso_div = 8'd3;
    lines    = 24'd9;
    run      = 8'h03;
    wait_until(c + FIRST + 2 * LP + 150);
    chk("latch_line_count", line_count, 2);
    chk("latch_steps", step_rises, 2);
    chk("hold_no_restart_busy", busy, 0);
    check_drained("latch");
    exp_dir    = 1'b1;
    step_rises = 0;
    start_scan(1, 3, 1, c);
    push_lines(c, 1, LP, 4);
    q_done.push_back(c + FIRST + LP);
    wait_until(c + 2);
    chk("rearm_count_cleared", line_count, 0);
    chk("rearm_busy", busy, 1);
    wait_until(c + FIRST + LP + 3);
    chk("rearm_line_count", line_count, 1);
    chk("rearm_steps", step_rises, 4);
    check_drained("rearm");

    // Asynchronous reset in the middle of a step pulse.
    exp_dir = 1'b0;
    start_scan(3, 0, 0, c);
    push_lines(c, 3, LP, 1);
    q_done.push_back(c + FIRST + 3 * LP);
    wait_until(c + FIRST + LP + 5);
    #1;
    chk("pre_reset_step", motor_step, 1);
    chk("pre_reset_count", line_count, 1);
    rst = 1'b1;
    #1;
    chk("rst_line_start", line_start, 0);
    chk("rst_motor_en", motor_en, 0);
    chk("rst_motor_step", motor_step, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_line_count", line_count, 0);
    q_ls.delete();
    q_step.delete();
    q_done.delete();
    repeat (3) @(posedge clk_100M);
    #2 rst = 1'b0;
    wait_until(cyc + 60);
    chk("post_rst_held_run_busy", busy, 0);
    chk("post_rst_held_run_en", motor_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
